// File: rtl/peripheral_ctrl.sv
// Memory-mapped peripheral block: timer, LED/switch/7-seg registers, UART byte queues.
// Latency: register reads are combinational, writes land on the next clk edge; irqout lags by one cycle.
// Backpressure: full TX queue drops writes (tx_ovf); full RX queue drops bytes (rx_ovf); tx_busy stalls TX drain.

// Generic single-clock FIFO with registered pointers and combinational head.
// Latency: a pushed entry is visible at out_dat one cycle after the push edge.
// Backpressure: in_rdy low when full, but a push alongside a pop is still accepted.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign out_vld = (cnt != '0);
    assign in_rdy  = (cnt < (AW+1)'(DEPTH));
    assign do_pop  = out_vld && out_rdy;
    assign do_push = in_vld && (in_rdy || do_pop);
    // An empty queue presents zero so callers need no extra gating.
    assign out_dat = out_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= in_dat;
    end
endmodule

// Peripheral register block on a simple rd/wr strobe bus.
// Latency: rdata combinational; register and queue updates on the next edge; irqout registered.
// Backpressure: none on the bus; UART queues drop on overflow and flag sticky ovf bits.
module peripheral_ctrl #(
    parameter logic [31:0] BASE       = 32'h4000_0000,
    parameter int          LED_W      = 8,
    parameter int          SW_W       = 8,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd,
    input  logic             wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  switch,
    output logic [11:0]      digi,
    output logic             irqout,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid
);
    localparam logic [31:0] A_TH   = BASE;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_LED  = BASE + 32'h0C;
    localparam logic [31:0] A_SW   = BASE + 32'h10;
    localparam logic [31:0] A_DIGI = BASE + 32'h14;
    localparam logic [31:0] A_TXD  = BASE + 32'h18;
    localparam logic [31:0] A_RXD  = BASE + 32'h1C;
    localparam logic [31:0] A_CON  = BASE + 32'h20;

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic        rx_ie;
    logic        tx_ie;
    logic        rx_ovf;
    logic        tx_ovf;
    logic [31:0] led_ext;
    logic [31:0] sw_ext;

    logic        tl_wr;
    logic        tcon_wr;
    logic        con_wr;
    logic        tl_wrap;
    logic        tx_push;
    logic        tx_go;
    logic        tx_drop;
    logic        rx_pop;
    logic        rx_drop;
    logic        tx_in_rdy;
    logic        tx_out_vld;
    logic [7:0]  tx_head;
    logic        rx_in_rdy;
    logic        rx_out_vld;
    logic [7:0]  rx_head;

    assign tl_wr   = wr && (addr == A_TL);
    assign tcon_wr = wr && (addr == A_TCON);
    assign con_wr  = wr && (addr == A_CON);
    assign tl_wrap = tcon[0] && (tl == 32'hFFFF_FFFF);

    assign tx_push = wr && (addr == A_TXD);
    // One idle cycle after every tx_start so the serializer can raise tx_busy.
    assign tx_go   = tx_out_vld && !tx_busy && !tx_start;
    assign tx_drop = tx_push && !tx_in_rdy && !tx_go;
    assign rx_pop  = rd && (addr == A_RXD);
    assign rx_drop = rx_valid && !rx_in_rdy && !rx_pop;

    fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (reset),
        .in_vld  (tx_push),
        .in_dat  (wdata[7:0]),
        .in_rdy  (tx_in_rdy),
        .out_vld (tx_out_vld),
        .out_dat (tx_head),
        .out_rdy (tx_go)
    );

    fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (reset),
        .in_vld  (rx_valid),
        .in_dat  (rx_data),
        .in_rdy  (rx_in_rdy),
        .out_vld (rx_out_vld),
        .out_dat (rx_head),
        .out_rdy (rx_pop)
    );

    // A CPU write to TL or TCON overrides the timer tick, including the reload flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr && (addr == A_TH)) th <= wdata;
            if (tl_wr)        tl <= wdata;
            else if (tcon[0]) tl <= tl_wrap ? th : tl + 32'd1;
            if (tcon_wr)
                tcon <= wdata[2:0];
            else if (tl_wrap && !tl_wr && tcon[1])
                tcon[2] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led      <= '0;
            digi     <= '0;
            rx_ie    <= 1'b0;
            tx_ie    <= 1'b0;
            rx_ovf   <= 1'b0;
            tx_ovf   <= 1'b0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            irqout   <= 1'b0;
        end else begin
            if (wr && (addr == A_LED))  led  <= wdata[LED_W-1:0];
            if (wr && (addr == A_DIGI)) digi <= wdata[11:0];
            if (con_wr) begin
                rx_ie <= wdata[0];
                tx_ie <= wdata[1];
            end
            rx_ovf   <= rx_drop | (rx_ovf & ~(con_wr & wdata[2]));
            tx_ovf   <= tx_drop | (tx_ovf & ~(con_wr & wdata[3]));
            tx_start <= tx_go;
            if (tx_go) tx_data <= tx_head;
            irqout   <= tcon[2] | (rx_ie & rx_out_vld) | (tx_ie & ~tx_out_vld);
        end
    end

    always_comb begin
        led_ext              = '0;
        led_ext[LED_W-1:0]   = led;
        sw_ext               = '0;
        sw_ext[SW_W-1:0]     = switch;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if      (addr == A_TH)   rdata = th;
            else if (addr == A_TL)   rdata = tl;
            else if (addr == A_TCON) rdata = {29'd0, tcon};
            else if (addr == A_LED)  rdata = led_ext;
            else if (addr == A_SW)   rdata = sw_ext;
            else if (addr == A_DIGI) rdata = {20'd0, digi};
            else if (addr == A_RXD)  rdata = {24'd0, rx_head};
            else if (addr == A_CON)
                rdata = {26'd0, ~tx_in_rdy, rx_out_vld, tx_ovf, rx_ovf, tx_ie, rx_ie};
        end
    end
endmodule

// File: tb/tb_peripheral_ctrl.sv
// Self-checking bench for peripheral_ctrl: register table, timer corners, UART queues, async reset.
module tb_peripheral_ctrl;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] A_TH   = BASE;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_LED  = BASE + 32'h0C;
    localparam logic [31:0] A_SW   = BASE + 32'h10;
    localparam logic [31:0] A_DIGI = BASE + 32'h14;
    localparam logic [31:0] A_TXD  = BASE + 32'h18;
    localparam logic [31:0] A_RXD  = BASE + 32'h1C;
    localparam logic [31:0] A_CON  = BASE + 32'h20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic [7:0]  sw = 8'h5A;
    logic [11:0] digi;
    logic        irqout;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;

    int checks = 0;
    int failures = 0;
    int tx_starts = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    typedef struct {
        logic        do_wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[12];

    peripheral_ctrl #(.BASE(BASE), .LED_W(8), .SW_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .led      (led),
        .switch   (sw),
        .digi     (digi),
        .irqout   (irqout),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        #1 d = rdata;
        rd = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] b);
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
        write_reg(A_TXD, {24'd0, b});
    endtask

    task automatic rx_send(input logic [7:0] b);
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        rx_valid = 1'b1; rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic rx_read(input string name);
        logic [31:0] v;
        logic [31:0] exp;
        exp = (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'd0;
        read_reg(A_RXD, v);
        check(name, v, exp);
    endtask

    task automatic rx_simul(input string name, input logic [7:0] b);
        logic [31:0] v;
        logic [31:0] exp;
        rd = 1'b1; addr = A_RXD; rx_valid = 1'b1; rx_data = b;
        #1 v = rdata;
        exp = (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'd0;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        check(name, v, exp);
        @(negedge clk);
        rd = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic tx_drain(input string name);
        for (int c = 0; c < 40 && tx_q.size() != 0; c++) begin
            @(negedge clk);
            #1;
        end
        check(name, tx_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && tx_start) begin
            tx_starts++;
            if (tx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected_start: got tx_data=0x%0h required no tx_start", tx_data);
            end else begin
                check("tx_byte", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int t0;

        vecs[0]  = '{1'b1, A_TH,   32'h1234_5678, 32'h1234_5678, "th_rw"};
        vecs[1]  = '{1'b1, A_TL,   32'hCAFE_0001, 32'hCAFE_0001, "tl_rw"};
        vecs[2]  = '{1'b1, A_TCON, 32'hFFFF_FFF8, 32'h0000_0000, "tcon_mask"};
        vecs[3]  = '{1'b1, A_LED,  32'h0000_01A5, 32'h0000_00A5, "led_trunc"};
        vecs[4]  = '{1'b1, A_DIGI, 32'hFFFF_ABCD, 32'h0000_0BCD, "digi_trunc"};
        vecs[5]  = '{1'b1, A_SW,   32'hFFFF_FFFF, 32'h0000_005A, "switch_ro"};
        vecs[6]  = '{1'b0, BASE + 32'h24,  32'h0, 32'h0, "unmapped_24"};
        vecs[7]  = '{1'b1, BASE + 32'h100, 32'hDEAD_BEEF, 32'h0, "unmapped_100"};
        vecs[8]  = '{1'b1, A_CON,  32'h0000_003F, 32'h0000_0003, "con_ie_rw"};
        vecs[9]  = '{1'b1, A_CON,  32'h0000_0000, 32'h0000_0000, "con_clear"};
        vecs[10] = '{1'b0, A_TH,   32'h0, 32'h1234_5678, "th_hold"};
        vecs[11] = '{1'b0, A_TXD,  32'h0, 32'h0, "txd_wo"};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_led", {24'd0, led}, 32'h0);
        check("rst_digi", {20'd0, digi}, 32'h0);
        check("rst_irq", {31'd0, irqout}, 32'h0);
        check("rst_tx_start", {31'd0, tx_start}, 32'h0);
        peek(A_TL, v);   check("rst_tl", v, 32'h0);
        peek(A_CON, v);  check("rst_con", v, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Register map table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) write_reg(vecs[i].a, vecs[i].d);
            read_reg(vecs[i].a, v);
            check(vecs[i].name, v, vecs[i].exp);
        end
        check("led_port", {24'd0, led}, 32'hA5);
        check("digi_port", {20'd0, digi}, 32'hBCD);

        // Timer reload with sticky flag and delayed irq
        write_reg(A_TH, 32'hFFFF_FFFE);
        write_reg(A_TL, 32'hFFFF_FFFE);
        write_reg(A_TCON, 32'h3);
        peek(A_TL, v);   check("tmr_tl_start", v, 32'hFFFF_FFFE);
        @(negedge clk);
        peek(A_TL, v);   check("tmr_tl_max", v, 32'hFFFF_FFFF);
        @(negedge clk);
        peek(A_TL, v);   check("tmr_tl_reload", v, 32'hFFFF_FFFE);
        peek(A_TCON, v); check("tmr_tcon_flag", v, 32'h7);
        check("tmr_irq_lag", {31'd0, irqout}, 32'h0);
        @(negedge clk);
        check("tmr_irq", {31'd0, irqout}, 32'h1);
        write_reg(A_TCON, 32'h0);

        // Same-cycle TL write wins over reload
        write_reg(A_TL, 32'hFFFF_FFFE);
        write_reg(A_TCON, 32'h3);
        @(negedge clk);
        peek(A_TL, v);   check("wc_tl_max", v, 32'hFFFF_FFFF);
        write_reg(A_TL, 32'h5);
        peek(A_TL, v);   check("wc_tl", v, 32'h5);
        peek(A_TCON, v); check("wc_tcon", v, 32'h3);
        write_reg(A_TCON, 32'h0);

        // TX overflow while busy, then drain in order
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) tx_write(8'hA1 + 8'(i));
        read_reg(A_CON, v); check("tx_con_ovf_full", v, 32'h28);
        check("tx_hold_busy", tx_starts, 0);
        write_reg(A_CON, 32'h8);
        read_reg(A_CON, v); check("tx_ovf_clear", v, 32'h20);
        t0 = tx_starts;
        tx_busy = 1'b0;
        tx_drain("tx_drain");
        repeat (3) @(negedge clk);
        check("tx_start_count", tx_starts - t0, 4);
        check("tx_data_hold", {24'd0, tx_data}, 32'hA4);

        // RX overflow, ordered reads, irq follows occupancy
        write_reg(A_CON, 32'h1);
        for (int i = 0; i < 5; i++) rx_send(8'(8'h11 * (i + 1)));
        read_reg(A_CON, v); check("rx_con_ovf", v, 32'h15);
        check("rx_irq_set", {31'd0, irqout}, 32'h1);
        for (int i = 0; i < 4; i++) rx_read("rx_byte");
        check("rx_irq_hold", {31'd0, irqout}, 32'h1);
        @(negedge clk);
        check("rx_irq_drop", {31'd0, irqout}, 32'h0);
        rx_read("rx_empty_read");
        write_reg(A_CON, 32'h4);
        read_reg(A_CON, v); check("rx_ovf_clear", v, 32'h0);

        // Push and pop together on a full and on an empty RX queue
        for (int i = 0; i < 4; i++) rx_send(8'h61 + 8'(i));
        rx_simul("rx_simul_full", 8'h65);
        read_reg(A_CON, v); check("rx_simul_no_ovf", v, 32'h10);
        for (int i = 0; i < 5; i++) rx_read("rx_simul_order");
        rx_simul("rx_simul_empty", 8'h77);
        rx_read("rx_simul_stored");
        rx_read("rx_simul_drained");

        // Async reset between edges with queued TX and RX bytes
        write_reg(A_CON, 32'h1);
        tx_busy = 1'b1;
        tx_write(8'hC1);
        tx_write(8'hC2);
        rx_send(8'h99);
        @(negedge clk);
        check("rst_pre_irq", {31'd0, irqout}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_tx_data", {24'd0, tx_data}, 32'h0);
        check("arst_tx_start", {31'd0, tx_start}, 32'h0);
        check("arst_led", {24'd0, led}, 32'h0);
        check("arst_digi", {20'd0, digi}, 32'h0);
        check("arst_irq", {31'd0, irqout}, 32'h0);
        peek(A_CON, v); check("arst_con", v, 32'h0);
        tx_q.delete();
        rx_q.delete();
        t0 = tx_starts;
        tx_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("arst_no_tx", tx_starts - t0, 0);
        rx_read("arst_rx_dropped");
        tx_write(8'hB7);
        tx_drain("arst_new_tx");
        repeat (2) @(negedge clk);
        check("arst_new_tx_data", {24'd0, tx_data}, 32'hB7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/peripheral_ctrl.md
PERIPHERAL_CTRL -- requirements
Module: peripheral_ctrl

Interface
REQ-001 SHALL have parameter BASE, default 32'h4000_0000, meaning the byte base address of the register map.
REQ-002 SHALL have parameter LED_W, default 8, meaning the LED register width (1..32).
REQ-003 SHALL have parameter SW_W, default 8, meaning the switch input width (1..32).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the depth of each UART FIFO (power of 2, >=2).
REQ-005 SHALL have ports: clk in 1 system clock; reset in 1 asynchronous, active-high.
REQ-006 SHALL have ports: rd in 1 read strobe; wr in 1 write strobe; addr in 32 byte address; wdata in 32 write data; rdata out 32 read data.
REQ-007 SHALL have ports: led out LED_W; switch in SW_W; digi out 12 seven-segment drive; irqout out 1 interrupt request.
REQ-008 SHALL have ports: tx_data out 8; tx_start out 1 one-cycle send pulse; tx_busy in 1 serializer busy; rx_data in 8; rx_valid in 1 one-cycle received-byte pulse.

Function
REQ-009 SHALL decode word offsets from BASE: 0x00 TH, 0x04 TL, 0x08 TCON[2:0], 0x0C LED, 0x10 SWITCH (read-only), 0x14 DIGI[11:0], 0x18 UART_TXD (write-only), 0x1C UART_RXD (read-only), 0x20 UART_CON.
REQ-010 SHALL drive rdata combinationally, zero-extended, when rd=1 and the address matches; otherwise rdata=0, including unmapped addresses and UART_TXD.
REQ-011 SHALL apply register writes on the rising clk edge when wr=1; writes to read-only or unmapped offsets have no effect.
REQ-012 Timer: when TCON[0]=1, TL SHALL increment by 1 each cycle; when TL=32'hFFFF_FFFF it SHALL reload TH instead, and if TCON[1]=1 it SHALL set TCON[2] (sticky).
REQ-013 A CPU write to TL or TCON SHALL take priority over the timer increment or reload in the same cycle.
REQ-014 UART_CON bits: [0] rx_ie, [1] tx_ie (read/write); [2] rx_ovf, [3] tx_ovf (sticky, cleared by writing 1); [4] rx_not_empty, [5] tx_full (read-only).
REQ-015 Writing UART_TXD SHALL push wdata[7:0] into the TX FIFO; when full, the byte SHALL be dropped and tx_ovf set.
REQ-016 TX drain SHALL pop the head onto tx_data and pulse tx_start for one cycle when the FIFO is non-empty, tx_busy=0 and tx_start was 0 in the previous cycle.
REQ-017 tx_data SHALL hold the last popped byte until the next pop.
REQ-018 rx_valid=1 SHALL push rx_data into the RX FIFO; when full and not popped in the same cycle, the byte SHALL be dropped and rx_ovf set.
REQ-019 A read of UART_RXD SHALL return the RX head and pop one entry per cycle in which rd=1 and the address matches; when the FIFO is empty it SHALL return 0 and not pop.
REQ-020 A simultaneous push and pop SHALL both succeed on a full or non-empty FIFO and leave the count unchanged; on an empty RX FIFO the read SHALL return 0 and the pushed byte SHALL be stored.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range 0..FIFO_DEPTH.
REQ-022 irqout SHALL be registered and equal TCON[2] | (rx_ie & rx_not_empty) | (tx_ie & tx_fifo_empty) as of the previous cycle.

Reset
REQ-023 On reset=1, asynchronously: TH=0, TL=0, TCON=0, led=0, digi=0, UART_CON=0, both FIFOs empty with pointers 0, tx_data=0, tx_start=0, irqout=0.
REQ-024 Reset asserted mid-transmit SHALL drop pending TX and RX bytes, with no tx_start pulse until a new write occurs after release.

Verification
REQ-025 Timer: TH=0xFFFF_FFFE, TL=0xFFFF_FFFE, TCON=3 -> TL goes ...FFFF, then 0xFFFF_FFFE; TCON[2]=1; irqout=1 one cycle later.
REQ-026 Write conflict: TL=0xFFFF_FFFF with TCON[0]=1 and a same-cycle write TL=5 -> TL=5, TCON[2] unchanged.
REQ-027 TX: 5 writes to UART_TXD with FIFO_DEPTH=4 and tx_busy=1 -> 4 bytes queued, tx_ovf=1; release tx_busy -> bytes 1-4 emitted in order, one tx_start per byte.
REQ-028 RX: 5 rx_valid pulses (0x11..0x55) -> reads return 0x11..0x44, then 0; rx_ovf=1; with rx_ie=1, irqout deasserts after the 4th read.
REQ-029 Simultaneous RX push and pop on a full FIFO -> count stays 4, no overflow, order preserved.
REQ-030 Reset pulse asserted between clock edges during a queued transmit -> all outputs 0 immediately, no tx_start follows.
